// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding for the LED bank controller.
// Modes advance in a fixed ring on each debounced button press.
package led_ctrl_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_MIRROR = 2'd0;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_SCAN   = 2'd2;
  localparam logic [MODE_W-1:0] MODE_COUNT  = 2'd3;

  function automatic logic [MODE_W-1:0] mode_next(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] n;
    case (m)
      MODE_MIRROR: n = MODE_BLINK;
      MODE_BLINK:  n = MODE_SCAN;
      MODE_SCAN:   n = MODE_COUNT;
      default:     n = MODE_MIRROR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a whole-vector stability filter.
// The output only follows the synchronised input after DEB_CYCLES consecutive differing cycles.
module input_debounce #(
  parameter int W          = 1,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [W-1:0]     r_meta;
  logic [W-1:0]     r_sync;
  logic [W-1:0]     r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_done;

  // One shared counter: a different bit changing mid-count keeps the run going.
  assign w_diff = (r_sync != r_db);
  assign w_done = (r_cnt == CNT_W'(DEB_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= '0;
      r_sync <= '0;
      r_db   <= '0;
      r_cnt  <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
      if (w_diff) begin
        if (w_done) begin
          r_db  <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign q_o = r_db;

endmodule

// File: rtl/led_bank_ctrl.sv
// Switch/LED bank controller: debounced inputs, mode ring, step prescaler and four display modes.
// led_o and mode_o are registered from next-state values so both change on the same edge.
module led_bank_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  sw_i,
  input  logic              btn_i,
  output logic [WIDTH-1:0]  led_o,
  output logic [MODE_W-1:0] mode_o
);

  localparam int PW    = $clog2(STEP_CYCLES);
  localparam int POS_W = $clog2(WIDTH);

  logic [WIDTH-1:0]  w_sw_db;
  logic              w_btn_db;
  logic              r_btn_prev;
  logic              w_adv;
  logic              w_tick;

  logic [MODE_W-1:0] r_mode;
  logic [PW-1:0]     r_presc;
  logic              r_phase;
  logic [POS_W-1:0]  r_pos;
  logic              r_dir_dn;
  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_led;

  logic [MODE_W-1:0] w_mode_nxt;
  logic [PW-1:0]     w_presc_nxt;
  logic              w_phase_nxt;
  logic [POS_W-1:0]  w_pos_nxt;
  logic              w_dir_dn_nxt;
  logic [WIDTH-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0]  w_led_nxt;

  input_debounce #(
    .W          (WIDTH),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_deb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sw_i),
    .q_o   (w_sw_db)
  );

  input_debounce #(
    .W          (1),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_deb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_i),
    .q_o   (w_btn_db)
  );

  assign w_adv  = w_btn_db & ~r_btn_prev;
  assign w_tick = (r_presc == PW'(STEP_CYCLES - 1));

  always_comb begin
    w_mode_nxt   = r_mode;
    w_presc_nxt  = r_presc + PW'(1);
    w_phase_nxt  = r_phase;
    w_pos_nxt    = r_pos;
    w_dir_dn_nxt = r_dir_dn;
    w_cnt_nxt    = r_cnt;
    // A mode change restarts every animation and swallows a coincident tick.
    if (w_adv) begin
      w_mode_nxt   = mode_next(r_mode);
      w_presc_nxt  = '0;
      w_phase_nxt  = 1'b0;
      w_pos_nxt    = '0;
      w_dir_dn_nxt = 1'b0;
      w_cnt_nxt    = '0;
    end else if (w_tick) begin
      w_presc_nxt = '0;
      case (r_mode)
        MODE_BLINK: w_phase_nxt = ~r_phase;
        MODE_SCAN: begin
          if (!r_dir_dn) begin
            w_pos_nxt = r_pos + POS_W'(1);
            if (w_pos_nxt == POS_W'(WIDTH - 1)) w_dir_dn_nxt = 1'b1;
          end else begin
            w_pos_nxt = r_pos - POS_W'(1);
            if (w_pos_nxt == '0) w_dir_dn_nxt = 1'b0;
          end
        end
        MODE_COUNT: w_cnt_nxt = r_cnt + WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_led_nxt = '0;
    case (w_mode_nxt)
      MODE_MIRROR: w_led_nxt = w_sw_db;
      MODE_BLINK:  w_led_nxt = w_phase_nxt ? w_sw_db : '0;
      MODE_SCAN:   w_led_nxt = WIDTH'(1) << w_pos_nxt;
      default:     w_led_nxt = w_cnt_nxt;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_btn_prev <= 1'b0;
      r_mode     <= MODE_MIRROR;
      r_presc    <= '0;
      r_phase    <= 1'b0;
      r_pos      <= '0;
      r_dir_dn   <= 1'b0;
      r_cnt      <= '0;
      r_led      <= '0;
    end else begin
      r_btn_prev <= w_btn_db;
      r_mode     <= w_mode_nxt;
      r_presc    <= w_presc_nxt;
      r_phase    <= w_phase_nxt;
      r_pos      <= w_pos_nxt;
      r_dir_dn   <= w_dir_dn_nxt;
      r_cnt      <= w_cnt_nxt;
      r_led      <= w_led_nxt;
    end
  end

  assign led_o  = r_led;
  assign mode_o = r_mode;

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Bench for led_bank_ctrl with short debounce/step periods: vector table, directed mode
// sequences, then random stimulus against a tick-counting reference model.
module tb_led_bank_ctrl;

  localparam int W    = 7;
  localparam int DEB  = 4;
  localparam int STEP = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw  = '0;
  logic         btn = 1'b0;
  logic [W-1:0] led;
  logic [1:0]   mode;

  int checks   = 0;
  int failures = 0;

  led_bank_ctrl #(
    .WIDTH       (W),
    .DEB_CYCLES  (DEB),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .sw_i   (sw),
    .btn_i  (btn),
    .led_o  (led),
    .mode_o (mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Assumes button debounced low; leaves btn held on the edge where mode_o changes.
  task automatic press(input logic [1:0] m_from, input logic [1:0] m_to);
    btn = 1'b1;
    repeat (6) step();
    chk("mode_before_adv", 32'(mode), 32'(m_from));
    step();
    chk("mode_after_adv", 32'(mode), 32'(m_to));
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_sw_h1, m_sw_h2, m_sw_db;
  logic         m_btn_h1, m_btn_h2, m_btn_db, m_btn_db_prev;
  int           m_sw_run, m_btn_run, m_mode, m_since;
  logic [W-1:0] m_led;

  task automatic model_reset();
    m_sw_h1 = '0; m_sw_h2 = '0; m_sw_db = '0; m_sw_run = 0;
    m_btn_h1 = 0; m_btn_h2 = 0; m_btn_db = 0; m_btn_db_prev = 0; m_btn_run = 0;
    m_mode = 0; m_since = 0; m_led = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] sw_in, input logic btn_in);
    int t, p, pos;
    if (m_btn_db && !m_btn_db_prev) begin
      m_mode  = (m_mode + 1) % 4;
      m_since = 0;
    end else begin
      m_since++;
    end
    t = m_since / STEP;
    case (m_mode)
      0: m_led = m_sw_db;
      1: m_led = (t % 2) ? m_sw_db : '0;
      2: begin
        p   = t % (2 * W - 2);
        pos = (p < W) ? p : (2 * W - 2 - p);
        m_led = W'(1) << pos;
      end
      default: m_led = W'(t % (1 << W));
    endcase
    m_btn_db_prev = m_btn_db;
    if (m_sw_h2 != m_sw_db) begin
      m_sw_run++;
      if (m_sw_run == DEB) begin m_sw_db = m_sw_h2; m_sw_run = 0; end
    end else m_sw_run = 0;
    if (m_btn_h2 != m_btn_db) begin
      m_btn_run++;
      if (m_btn_run == DEB) begin m_btn_db = m_btn_h2; m_btn_run = 0; end
    end else m_btn_run = 0;
    m_sw_h2 = m_sw_h1; m_sw_h1 = sw_in;
    m_btn_h2 = m_btn_h1; m_btn_h1 = btn_in;
  endtask

  typedef struct {
    logic [W-1:0] sw;
    int           cyc;
    logic [W-1:0] led;
  } vec_t;

  vec_t         tab[12];
  logic [W-1:0] scan_tab[14];
  logic [W-1:0] exp_led;

  initial begin
    int sw_hold, btn_hold;

    tab[0]  = '{7'h55, 6, 7'h00};  // one clock short of 2+4+1
    tab[1]  = '{7'h55, 1, 7'h55};
    tab[2]  = '{7'h7F, 3, 7'h55};  // 3-clock glitch
    tab[3]  = '{7'h55, 6, 7'h55};
    tab[4]  = '{7'h7F, 6, 7'h55};
    tab[5]  = '{7'h7F, 1, 7'h7F};
    tab[6]  = '{7'h2A, 7, 7'h2A};
    tab[7]  = '{7'h00, 7, 7'h00};
    tab[8]  = '{7'h01, 7, 7'h01};
    tab[9]  = '{7'h03, 3, 7'h01};  // other bit changes mid-count
    tab[10] = '{7'h07, 3, 7'h01};
    tab[11] = '{7'h07, 1, 7'h07};
    scan_tab = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h20,
                 7'h10, 7'h08, 7'h04, 7'h02, 7'h01, 7'h02, 7'h04};

    repeat (2) @(posedge clk);
    chk("reset_led", 32'(led), 0);
    chk("reset_mode", 32'(mode), 0);
    #1 rst = 1'b0;
    step();
    chk("post_reset_led", 32'(led), 0);

    for (int i = 0; i < 12; i++) begin
      sw = tab[i].sw;
      repeat (tab[i].cyc) step();
      chk($sformatf("mirror_vec%0d", i), 32'(led), 32'(tab[i].led));
      chk($sformatf("mirror_mode%0d", i), 32'(mode), 0);
    end

    // BLINK: 8 clocks dark, 8 clocks showing sw_db; button held 20 clocks
    press(2'd0, 2'd1);
    for (int n = 0; n < 24; n++) begin
      if (n > 0) step();
      if (n == 13) btn = 1'b0;
      exp_led = ((n / 8) % 2) ? 7'h07 : 7'h00;
      chk("blink_led", 32'(led), 32'(exp_led));
      chk("blink_mode", 32'(mode), 1);
    end

    // SCAN: 14 ticks
    press(2'd1, 2'd2);
    for (int n = 0; n <= 112; n++) begin
      if (n > 0) step();
      if (n == 13) btn = 1'b0;
      exp_led = (n < 8) ? 7'h01 : scan_tab[n / 8 - 1];
      chk("scan_led", 32'(led), 32'(exp_led));
    end
    step();
    // mode change lands on a tick edge: no scan step, count starts at 0
    press(2'd2, 2'd3);
    chk("tick_adv_led", 32'(led), 0);

    // COUNT: 130 ticks
    for (int n = 0; n <= 1040; n++) begin
      if (n > 0) step();
      if (n == 13) btn = 1'b0;
      chk("count_led", 32'(led), 32'((n / 8) % 128));
    end
    press(2'd3, 2'd0);
    chk("wrap_mirror_led", 32'(led), 32'h07);
    btn = 1'b0;
    repeat (10) step();
    chk("release_no_adv", 32'(mode), 0);

    // async reset in the middle of SCAN
    press(2'd0, 2'd1);
    btn = 1'b0;
    repeat (10) step();
    press(2'd1, 2'd2);
    btn = 1'b0;
    repeat (13) step();
    chk("scan_before_rst", 32'(led), 32'h02);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 0);
    chk("async_rst_mode", 32'(mode), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("rst_release_led", 32'(led), 0);
    chk("rst_release_mode", 32'(mode), 0);

    // random stimulus against the model
    rst = 1'b1;
    sw  = '0;
    btn = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    sw_hold  = 0;
    btn_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (sw_hold == 0) begin
        sw      = W'($urandom);
        sw_hold = $urandom_range(1, 8);
      end
      if (btn_hold == 0) begin
        btn      = ~btn;
        btn_hold = $urandom_range(1, 30);
      end
      sw_hold--;
      btn_hold--;
      model_edge(sw, btn);
      step();
      chk("rand_led", 32'(led), 32'(m_led));
      chk("rand_mode", 32'(mode), 32'(m_mode));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
